// File: rtl/csr_pkg.sv
// Shared CSR address map and decode helpers for the RV32I machine-mode CSR file,
// used by the CSR file, the decoder and the hazard unit.
package csr_pkg;

  localparam logic [11:0] CSR_MCYCLE       = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH      = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET     = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH    = 12'hB82;
  localparam logic [11:0] CSR_CYCLE        = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH       = 12'hC80;
  localparam logic [11:0] CSR_INSTRET      = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH     = 12'hC82;
  localparam logic [11:0] CSR_MHARTID      = 12'hF14;
  localparam logic [11:0] CSR_SCRATCH_BASE = 12'h7C0;

  // Scratch window is the 64-entry block at 0x7C0; only the first n entries exist.
  function automatic logic scratch_hit(input logic [11:0] addr, input int unsigned n);
    return (addr[11:6] == CSR_SCRATCH_BASE[11:6]) && (32'(addr[5:0]) < n);
  endfunction

  // Only the machine-mode names are writable; user-mode shadows and mhartid are read-only.
  function automatic logic csr_writable(input logic [11:0] addr, input int unsigned n);
    return scratch_hit(addr, n) ||
           (addr inside {CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH});
  endfunction

endpackage

// File: rtl/csr_file_if.sv
// CSR file bus: EX-stage read port, WB-stage write port and the retire strobe.
interface csr_file_if;

  logic [11:0] csr_rd_addr_EX;
  logic [31:0] csr_rd_data_EX;
  logic        csr_illegal_EX;
  logic        csr_wb_en_WB;
  logic [11:0] csr_wb_addr_WB;
  logic [31:0] csr_wb_WB;
  logic        retire_WB;

  modport master (
    output csr_rd_addr_EX, csr_wb_en_WB, csr_wb_addr_WB, csr_wb_WB, retire_WB,
    input  csr_rd_data_EX, csr_illegal_EX
  );

  modport slave (
    input  csr_rd_addr_EX, csr_wb_en_WB, csr_wb_addr_WB, csr_wb_WB, retire_WB,
    output csr_rd_data_EX, csr_illegal_EX
  );

endinterface

// File: rtl/csr_counter64.sv
// 64-bit CSR counter written as two 32-bit halves; a half-write wins over the
// increment and the carry between halves is dropped in that cycle.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  logic [32:0] lo_sum;
  logic [31:0] hi_sum;

  always_comb begin
    lo_sum = {1'b0, value[31:0]} + {32'b0, inc};
    hi_sum = value[63:32] + {31'b0, lo_sum[32]};
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (wr_lo) begin
      value[31:0] <= wdata;
    end else if (wr_hi) begin
      value <= {wdata, lo_sum[31:0]};
    end else begin
      value <= {hi_sum, lo_sum[31:0]};
    end
  end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: scratch bank, mcycle/minstret and mhartid.
// Build option CSR_BYPASS_EN forwards a same-cycle WB write to the EX read port.
module csr_file
  import csr_pkg::*;
#(
  parameter int unsigned NUM_SCRATCH = 8,
  parameter logic [31:0] HART_ID     = 32'd0
) (
  input logic       clk,
  input logic       rst_n,
  csr_file_if.slave bus
);

  logic [31:0] scratch [NUM_SCRATCH];
  logic [63:0] mcycle;
  logic [63:0] minstret;
  logic        wr_scratch;

  assign wr_scratch = bus.csr_wb_en_WB && scratch_hit(bus.csr_wb_addr_WB, NUM_SCRATCH);

  // NOTE: scratch is architectural state that must read 0 after reset, so it
  // is a reset flop bank rather than a RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SCRATCH; i++) scratch[i] <= '0;
    end else if (wr_scratch) begin
      for (int i = 0; i < NUM_SCRATCH; i++)
        if (bus.csr_wb_addr_WB[5:0] == 6'(i)) scratch[i] <= bus.csr_wb_WB;
    end
  end

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (1'b1),
    .wr_lo (bus.csr_wb_en_WB && bus.csr_wb_addr_WB == CSR_MCYCLE),
    .wr_hi (bus.csr_wb_en_WB && bus.csr_wb_addr_WB == CSR_MCYCLEH),
    .wdata (bus.csr_wb_WB),
    .value (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bus.retire_WB),
    .wr_lo (bus.csr_wb_en_WB && bus.csr_wb_addr_WB == CSR_MINSTRET),
    .wr_hi (bus.csr_wb_en_WB && bus.csr_wb_addr_WB == CSR_MINSTRETH),
    .wdata (bus.csr_wb_WB),
    .value (minstret)
  );

  // NOTE: both outputs get defaults first so no path through the block infers a latch.
  always_comb begin
    bus.csr_rd_data_EX = '0;
    bus.csr_illegal_EX = 1'b0;
    if (scratch_hit(bus.csr_rd_addr_EX, NUM_SCRATCH)) begin
      for (int i = 0; i < NUM_SCRATCH; i++)
        if (bus.csr_rd_addr_EX[5:0] == 6'(i)) bus.csr_rd_data_EX = scratch[i];
    end else begin
      case (bus.csr_rd_addr_EX)
        CSR_MCYCLE,    CSR_CYCLE:    bus.csr_rd_data_EX = mcycle[31:0];
        CSR_MCYCLEH,   CSR_CYCLEH:   bus.csr_rd_data_EX = mcycle[63:32];
        CSR_MINSTRET,  CSR_INSTRET:  bus.csr_rd_data_EX = minstret[31:0];
        CSR_MINSTRETH, CSR_INSTRETH: bus.csr_rd_data_EX = minstret[63:32];
        CSR_MHARTID:                 bus.csr_rd_data_EX = HART_ID;
        default:                     bus.csr_illegal_EX = 1'b1;
      endcase
    end
`ifdef CSR_BYPASS_EN
    // Read-only shadows fail csr_writable, so they always return stored state.
    if (bus.csr_wb_en_WB && bus.csr_wb_addr_WB == bus.csr_rd_addr_EX &&
        csr_writable(bus.csr_wb_addr_WB, NUM_SCRATCH))
      bus.csr_rd_data_EX = bus.csr_wb_WB;
`else
    // Without forwarding the hazard unit stalls EX on a CSR RAW hazard.
`endif
  end

endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file; expectations follow CSR_BYPASS_EN when it is defined.
module tb_csr_file;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        illegal;
  } exp_t;

  logic clk;
  logic rst_n;
  logic chk_req;
  exp_t sb[$];
  int   total;
  int   bad;

  csr_file_if bus ();

  csr_file #(
    .NUM_SCRATCH (8),
    .HART_ID     (32'd3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: the read port is combinational, so sample mid-cycle on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (chk_req) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        check(e.name, bus.csr_rd_data_EX, e.data);
        check({e.name, "_illegal"}, {31'b0, bus.csr_illegal_EX}, {31'b0, e.illegal});
      end
    end
  end

  // One clock of stimulus: drives inputs just after the rising edge, optionally queues a read check.
  task automatic cyc(input logic wen, input logic [11:0] wa, input logic [31:0] wd,
                     input logic ret, input logic [11:0] ra, input logic chk,
                     input logic [31:0] ed, input logic ei, input string nm);
    exp_t e;
    bus.csr_wb_en_WB   = wen;
    bus.csr_wb_addr_WB = wa;
    bus.csr_wb_WB      = wd;
    bus.retire_WB      = ret;
    bus.csr_rd_addr_EX = ra;
    chk_req            = chk;
    if (chk) begin
      e.name = nm; e.data = ed; e.illegal = ei;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] wa, input logic [31:0] wd);
    cyc(1'b1, wa, wd, 1'b0, 12'h000, 1'b0, 32'd0, 1'b0, "");
  endtask

  task automatic rd(input logic [11:0] ra, input logic [31:0] ed, input logic ei, input string nm);
    cyc(1'b0, 12'h000, 32'd0, 1'b0, ra, 1'b1, ed, ei, nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] bypass_exp;
    total = 0;
    bad   = 0;
    chk_req = 1'b0;
    rst_n = 1'b0;
    bus.csr_wb_en_WB = 1'b0; bus.csr_wb_addr_WB = '0; bus.csr_wb_WB = '0;
    bus.retire_WB = 1'b0; bus.csr_rd_addr_EX = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    rd(12'hB00, 32'd0, 1'b0, "rst_mcycle");
    rd(12'h7C3, 32'd0, 1'b0, "rst_scratch3");
    rst_n = 1'b1;
    rd(12'hB02, 32'd0, 1'b0, "rst_minstret");

    // Scratch write/read, read-only shadow drop, unmapped read
    wr(12'h7C3, 32'hDEADBEEF);
    rd(12'h7C3, 32'hDEADBEEF, 1'b0, "scratch3");
    wr(12'h7C0, 32'hA5A5A5A5);
    wr(12'hB00, 32'd1000);
    cyc(1'b1, 12'hC00, 32'h55, 1'b0, 12'hB00, 1'b1, 32'd1000, 1'b0, "mcycle_after_wr");
    rd(12'hB00, 32'd1001, 1'b0, "shadow_wr_dropped");
    rd(12'h123, 32'd0, 1'b1, "unmapped");
    rd(12'h7C8, 32'd0, 1'b1, "scratch_oob");

    // mcycle carry from low to high
    wr(12'hB80, 32'd0);
    wr(12'hB00, 32'hFFFFFFFF);
    rd(12'hB00, 32'hFFFFFFFF, 1'b0, "carry_lo_pre");
    rd(12'hB80, 32'd1, 1'b0, "carry_hi");
    rd(12'hB00, 32'd1, 1'b0, "carry_lo_post");

    // High write while low overflows: carry discarded
    wr(12'hB00, 32'hFFFFFFFF);
    cyc(1'b1, 12'hB80, 32'hFFFFFFFF, 1'b0, 12'hB00, 1'b1, 32'hFFFFFFFF, 1'b0, "coll_lo_pre");
    rd(12'hB80, 32'hFFFFFFFF, 1'b0, "coll_hi");
    rd(12'hB00, 32'd1, 1'b0, "coll_lo");

    // All-ones wraps to zero
    wr(12'hB00, 32'hFFFFFFFF);
    rd(12'hB80, 32'hFFFFFFFF, 1'b0, "wrap_hi_pre");
    rd(12'hB80, 32'd0, 1'b0, "wrap_hi");
    rd(12'hB00, 32'd1, 1'b0, "wrap_lo");

    // minstret gating: 5 retires in 10 cycles
    wr(12'hB82, 32'd0);
    wr(12'hB02, 32'd0);
    for (int i = 0; i < 10; i++)
      cyc(1'b0, 12'h000, 32'd0, (i % 2 == 0), 12'h000, 1'b0, 32'd0, 1'b0, "");
    rd(12'hB02, 32'd5, 1'b0, "minstret_5");
    rd(12'hC82, 32'd0, 1'b0, "instreth_0");
    cyc(1'b1, 12'hB02, 32'd100, 1'b1, 12'hC02, 1'b1, 32'd5, 1'b0, "minstret_pre_wr");
    rd(12'hB02, 32'd100, 1'b0, "minstret_wr_wins");
    rd(12'hB02, 32'd100, 1'b0, "minstret_hold");

    // Same-cycle write and read of a writable address
`ifdef CSR_BYPASS_EN
    bypass_exp = 32'h12345678;
`else
    bypass_exp = 32'hA5A5A5A5;
`endif
    cyc(1'b1, 12'h7C0, 32'h12345678, 1'b0, 12'h7C0, 1'b1, bypass_exp, 1'b0, "bypass");
    rd(12'h7C0, 32'h12345678, 1'b0, "scratch0_after");
    // Read-only shadow is never forwarded
    wr(12'hB00, 32'd500);
    cyc(1'b1, 12'hC00, 32'h77, 1'b0, 12'hC00, 1'b1, 32'd500, 1'b0, "shadow_no_bypass");

    // mhartid
    rd(12'hF14, 32'd3, 1'b0, "mhartid");
    wr(12'hF14, 32'hFFFF);
    rd(12'hF14, 32'd3, 1'b0, "mhartid_ro");

    // Mid-run async reset with a write in flight
    bus.csr_wb_en_WB = 1'b1; bus.csr_wb_addr_WB = 12'h7C3; bus.csr_wb_WB = 32'h1111;
    #2;
    rst_n = 1'b0;
    cyc(1'b1, 12'h7C3, 32'h1111, 1'b1, 12'hB00, 1'b1, 32'd0, 1'b0, "midrst_mcycle");
    cyc(1'b1, 12'h7C3, 32'h1111, 1'b1, 12'hB02, 1'b1, 32'd0, 1'b0, "midrst_minstret");
    cyc(1'b1, 12'h7C3, 32'h1111, 1'b1, 12'h7C3, 1'b1, 32'd0, 1'b0, "midrst_scratch3");
    rst_n = 1'b1;
    rd(12'hB00, 32'd0, 1'b0, "release_0");
    rd(12'hB00, 32'd1, 1'b0, "release_1");
    rd(12'hB00, 32'd2, 1'b0, "release_2");
    rd(12'h7C3, 32'd0, 1'b0, "no_write_survives");

    chk_req = 1'b0;
    repeat (2) @(posedge clk);
    check("sb_drain", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
